// File: rtl/sprite_pkg.sv
// Shared sizing helpers, FSM state type and squared-radius type for the sprite rasterizer.
// Pure declarations: no logic, no latency, no flow control.
package sprite_pkg;

  localparam int RADIUS_WIDTH_DEFAULT = 6;

  typedef enum logic {IDLE = 1'b0, ROW = 1'b1} raster_state_t;

  // Sum of dy^2 and dx^2 at the default radius width, carried without truncation.
  typedef logic [2*RADIUS_WIDTH_DEFAULT:0] r2_t;

  function automatic int side(input int rw);
    return (1 << (rw + 1)) - 1;
  endfunction

  function automatic int center(input int rw);
    return (1 << rw) - 1;
  endfunction

endpackage

// File: rtl/sprite_row_mask.sv
// One row of the disc: bit j is set when dy2 + (j-CENTER)^2 < r2.
// Combinational, zero latency; no flow control of its own.
module sprite_row_mask
  import sprite_pkg::*;
#(
  parameter int RADIUS_WIDTH = 6
) (
  input  logic [2*RADIUS_WIDTH-1:0]     dy2,
  input  logic [2*RADIUS_WIDTH-1:0]     r2,
  output logic [side(RADIUS_WIDTH)-1:0] mask
);

  localparam int SIDE   = side(RADIUS_WIDTH);
  localparam int CENTER = center(RADIUS_WIDTH);
  localparam int SW     = 2*RADIUS_WIDTH + 1;

  logic [SW-1:0] dy2_ext;
  logic [SW-1:0] r2_ext;

  assign dy2_ext = {1'b0, dy2};
  assign r2_ext  = {1'b0, r2};

  // Column offsets are fixed, so each column is one adder plus one comparator.
  for (genvar j = 0; j < SIDE; j++) begin : g_col
    localparam logic [SW-1:0] DX2 = SW'((j - CENTER) * (j - CENTER));
    assign mask[j] = (dy2_ext + DX2) < r2_ext;
  end

endmodule

// File: rtl/sprite_rasterizer.sv
// Streams a SIDE x SIDE circle bitmap one row per handshake; SPRITE_RASTERIZER_OUTLINE_EN adds ring mode.
// First row valid 1 cycle after start accept, then 1 row/cycle; row_ready low holds the row stable.
module sprite_rasterizer
  import sprite_pkg::*;
#(
  parameter int RADIUS_WIDTH = 6,
  parameter int IDX_WIDTH    = RADIUS_WIDTH + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [RADIUS_WIDTH-1:0]       radius,
`ifdef SPRITE_RASTERIZER_OUTLINE_EN
  input  logic                          outline,
`endif
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [IDX_WIDTH-1:0]          row_index,
  output logic [side(RADIUS_WIDTH)-1:0] row_data,
  output logic                          row_last,
  output logic                          busy
);

  localparam int SIDE   = side(RADIUS_WIDTH);
  localparam int CENTER = center(RADIUS_WIDTH);
  localparam int RW2    = 2*RADIUS_WIDTH;

  localparam logic [RW2-1:0]       DY2_INIT = RW2'(CENTER * CENTER);
  localparam logic [IDX_WIDTH:0]   DY_INIT  = (IDX_WIDTH+1)'(-CENTER);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(SIDE - 1);

  raster_state_t        state_q, state_d;
  logic [RW2-1:0]       r2_q, r2_d;
  logic [RW2-1:0]       dy2_q, dy2_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  // Two's-complement row offset i-CENTER.
  logic [IDX_WIDTH:0]   dy_q, dy_d;

  logic [RW2-1:0]  r_ext;
  logic [RW2-1:0]  r_sq;
  logic [RW2-1:0]  dy_step;
  logic            at_last;
  logic [SIDE-1:0] fill_mask;
  logic [SIDE-1:0] mask;

  assign r_ext   = {{RADIUS_WIDTH{1'b0}}, radius};
  assign r_sq    = r_ext * r_ext;
  // 2*dy+1 sign-extended; modular add is exact since (i-CENTER)^2 always fits.
  assign dy_step = {{(RW2-IDX_WIDTH-1){dy_q[IDX_WIDTH]}}, dy_q[IDX_WIDTH-1:0], 1'b1};
  assign at_last = (idx_q == IDX_LAST);

  assign row_valid   = (state_q == ROW);
  assign busy        = (state_q == ROW);
  assign start_ready = (state_q == IDLE);
  assign row_index   = idx_q;
  assign row_last    = row_valid && at_last;
  assign row_data    = row_valid ? mask : '0;

  sprite_row_mask #(.RADIUS_WIDTH(RADIUS_WIDTH)) u_fill (
    .dy2  (dy2_q),
    .r2   (r2_q),
    .mask (fill_mask)
  );

`ifdef SPRITE_RASTERIZER_OUTLINE_EN
  logic            outline_q, outline_d;
  logic [RW2-1:0]  r2m1_q, r2m1_d;
  logic [RW2-1:0]  rm1_ext;
  logic [SIDE-1:0] inner_mask;

  assign rm1_ext = r_ext - RW2'(1);

  sprite_row_mask #(.RADIUS_WIDTH(RADIUS_WIDTH)) u_inner (
    .dy2  (dy2_q),
    .r2   (r2m1_q),
    .mask (inner_mask)
  );

  assign mask = outline_q ? (fill_mask & ~inner_mask) : fill_mask;

  always_comb begin
    outline_d = outline_q;
    r2m1_d    = r2m1_q;
    if (state_q == IDLE && start_valid) begin
      outline_d = outline;
      r2m1_d    = (radius == '0) ? '0 : rm1_ext * rm1_ext;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outline_q <= 1'b0;
      r2m1_q    <= '0;
    end else begin
      outline_q <= outline_d;
      r2m1_q    <= r2m1_d;
    end
  end
`else
  assign mask = fill_mask;
`endif

  always_comb begin
    state_d = state_q;
    r2_d    = r2_q;
    dy2_d   = dy2_q;
    idx_d   = idx_q;
    dy_d    = dy_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = ROW;
          r2_d    = r_sq;
          idx_d   = '0;
          dy2_d   = DY2_INIT;
          dy_d    = DY_INIT;
        end
      end
      ROW: begin
        if (row_ready) begin
          if (at_last) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
            dy2_d = dy2_q + dy_step;
            dy_d  = dy_q + (IDX_WIDTH+1)'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r2_q    <= '0;
      dy2_q   <= '0;
      idx_q   <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      r2_q    <= r2_d;
      dy2_q   <= dy2_d;
      idx_q   <= idx_d;
      dy_q    <= dy_d;
    end
  end

endmodule

// File: doc/sprite_rasterizer.md
Name: sprite_rasterizer

Overview:
- Sequential, parametrised successor to the combinational circle-sprite generator.
- Instead of building the full SIDE x SIDE bitmap in one cycle, it streams one row per handshake from a latched radius.
- Cuts comparator area from SIDE^2 to SIDE and scales radius width.
- Feeds the frame-buffer blitter that draws each body.

Parameters:
- RADIUS_WIDTH, 6: bits of radius. Derived localparams: SIDE = 2^(RADIUS_WIDTH+1)-1 (127 at default); CENTER = 2^RADIUS_WIDTH-1 (63).
- IDX_WIDTH, RADIUS_WIDTH+1: width of row_index.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start_valid  in  1  request to rasterize radius.
- start_ready  out  1  high only in IDLE.
- radius  in  RADIUS_WIDTH  circle radius, sampled on start handshake.
- row_valid  out  1  row_data/row_index/row_last valid.
- row_ready  in  1  consumer accepts the row.
- row_index  out  IDX_WIDTH  row number i, 0..SIDE-1.
- row_data  out  SIDE  bit j = pixel (i,j); bit 0 is column 0.
- row_last  out  1  high with row SIDE-1.
- busy  out  1  high in ROW state.

Behaviour:
- Reset values: start_ready=1, row_valid=0, row_index=0, row_data=0, row_last=0, busy=0.
- States: IDLE, ROW.
- IDLE:
  - start_valid && start_ready -> latch r, compute r2 = r*r (2*RADIUS_WIDTH bits, unsigned).
  - Set i=0, dy2=CENTER^2, dy=-CENTER (signed IDX_WIDTH+1), go to ROW.
- ROW:
  - row_valid=1 starting the cycle after the accept (1-cycle latency to first row).
  - Pixel rule: row_data[j] = (dy2 + (j-CENTER)^2) < r2. Strict less-than; identical to the prior block for every radius.
  - Column dx^2 values are elaboration constants; sum width is 2*RADIUS_WIDTH+1 bits, no truncation.
  - row_ready low -> row_valid, row_index, row_data and row_last hold stable.
  - row_valid && row_ready with i<SIDE-1 -> i++, dy2 += 2*dy+1, dy++. The next row is valid the next cycle, so one row per cycle under full throughput.
  - Handshake on row_last -> IDLE. start_ready rises the following cycle; no bubble beyond that.
- start_valid during ROW is ignored and not queued; the radius input may change freely while busy.
- radius=0: r2=0, all SIDE rows are emitted as all-zero (the frame is still complete).
- Maximum radius 2^RADIUS_WIDTH-1: rows 0 and SIDE-1 are empty because dy2 == r2 fails the strict compare.
- Reset asserted mid-frame: immediately row_valid=0 and state=IDLE; the partial frame is abandoned and the consumer must discard it.
- The incremental dy2 update must exactly match (i-CENTER)^2 at every row.

Optional Feature:
- Macro SPRITE_RASTERIZER_OUTLINE_EN.
- Defined:
  - Adds input port outline (1 bit), latched with radius on the start handshake.
  - When latched high, row_data[j] = inside(r) && !inside(r-1), giving a one-pixel ring. For r=0 the ring is empty; for r=1 it is the centre pixel only.
  - Requires a second comparator bank against (r-1)^2, also latched on start.
- Undefined: no outline port and no second comparator bank; always a filled disc.

Decomposition:
- Package sprite_pkg holds:
  - function side(rw) and function center(rw);
  - typedef enum logic {IDLE, ROW} raster_state_t;
  - r2_t sized 2*RADIUS_WIDTH+1.
- Sub-module sprite_row_mask: combinational; inputs dy2 and r2; output SIDE-bit mask. Generate loop over columns with constant dx^2. Instantiated once, or twice with the outline macro.

Test Plan:
- radius=1, row_ready tied high -> 127 rows in 127 consecutive cycles starting 1 cycle after accept. Only row 63 is nonzero, with row_data[63]=1 and all other bits 0. row_last only on row_index 126.
- radius=2 -> rows 62, 63 and 64 have bits 62..64 set (3'b111), all other rows zero. Check (2,0) excluded: dist 4 is not < 4.
- radius=63 -> rows 0 and 126 zero; row 63 has bits 1..125 set and bits 0 and 126 clear. Compare every row against a reference model of the (i-63)^2+(j-63)^2<3969 rule.
- Backpressure: row_ready low for 5 cycles while row 10 is presented -> row_index=10 and row_data stay unchanged. Assert start_valid with radius=5 during the stall -> start_ready=0 and the request is ignored; the frame completes with the original radius.
- Reset pulse at row 40 -> row_valid=0 and start_ready=1 in the same cycle (asynchronous). A fresh start with radius=3 then emits row 0 next cycle, correct and complete.
- With SPRITE_RASTERIZER_OUTLINE_EN, radius=2, outline=1 -> row 63 = bits 62 and 64 set, bit 63 clear. Rows 62 and 64 = bits 62..64 set.
